// File: rtl/hex_display_driver.sv
// hex_display_driver: shows a byte on the four DE10-Lite seven-segment digits,
// either as unsigned decimal with leading-zero blanking (double-dabble FSM)
// or as two hex digits, with global PWM brightness and an optional blink.
// update_done is a single-cycle pulse, registered, asserted on the cycle after
// new digits are committed; segment outputs follow one cycle later.
`timescale 1ns/1ps
module hex_display_driver #(
    parameter int BLINK_HALF = 25000000,
    parameter int PWM_PERIOD = 15
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] data_in,
    input  logic       hex_mode,
    input  logic       blink_en,
    input  logic [3:0] brightness,
    output logic [7:0] hex0,
    output logic [7:0] hex1,
    output logic [7:0] hex2,
    output logic [7:0] hex3,
    output logic       busy,
    output logic       update_done,
    output logic [1:0] o_dbg_state
);

    localparam int PCW = ($clog2(PWM_PERIOD) > 4) ? $clog2(PWM_PERIOD) : 4;
    localparam int BCW = $clog2(BLINK_HALF);
    localparam logic [4:0] DIG_BLANK = 5'h10;  // bit4 set = digit blank

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_CONVERT = 2'd2,
        S_COMMIT  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic             w_start;
    logic [7:0]       r_cap_val;
    logic             r_cap_mode;
    logic             r_force_pending;
    logic [11:0]      r_bcd;
    logic [7:0]       r_bin;
    logic [2:0]       r_iter;
    logic [11:0]      w_bcd_adj;
    logic [4:0]       r_dig [4];
    logic [7:0]       r_hex [4];
    logic             r_update_done;
    logic [PCW-1:0]   r_pwm_cnt;
    logic [BCW-1:0]   r_blink_cnt;
    logic             r_blink_phase;
    logic             w_dark;

    // Active-low segment pattern for one digit register; blank gives all off.
    function automatic logic [7:0] seg_enc(input logic [4:0] dig);
        logic [7:0] seg;
        case (dig[3:0])
            4'h0: seg = 8'hC0;
            4'h1: seg = 8'hF9;
            4'h2: seg = 8'hA4;
            4'h3: seg = 8'hB0;
            4'h4: seg = 8'h99;
            4'h5: seg = 8'h92;
            4'h6: seg = 8'h82;
            4'h7: seg = 8'hF8;
            4'h8: seg = 8'h80;
            4'h9: seg = 8'h90;
            4'hA: seg = 8'h88;
            4'hB: seg = 8'h83;
            4'hC: seg = 8'hC6;
            4'hD: seg = 8'hA1;
            4'hE: seg = 8'h86;
            default: seg = 8'h8E;
        endcase
        return dig[4] ? 8'hFF : seg;
    endfunction

    // Conversion starts whenever the shown value or mode is stale (or after reset).
    assign w_start = r_force_pending || (data_in != r_cap_val) || (hex_mode != r_cap_mode);

    // Add-3 correction of every BCD nibble that is 5 or more, before the shift.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int n = 0; n < 3; n++) begin
            if (r_bcd[n*4 +: 4] >= 4'd5)
                w_bcd_adj[n*4 +: 4] = r_bcd[n*4 +: 4] + 4'd3;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next_state;
    end

    // FSM next-state logic; hex mode needs no BCD conversion.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    if (w_start) w_next_state = S_LOAD;
            S_LOAD:    w_next_state = r_cap_mode ? S_COMMIT : S_CONVERT;
            S_CONVERT: if (r_iter == 3'd7) w_next_state = S_COMMIT;
            S_COMMIT:  w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    // Capture, double-dabble datapath and digit commit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cap_val       <= 8'd0;
            r_cap_mode      <= 1'b0;
            r_force_pending <= 1'b1;
            r_bcd           <= 12'd0;
            r_bin           <= 8'd0;
            r_iter          <= 3'd0;
            r_update_done   <= 1'b0;
            for (int i = 0; i < 4; i++) r_dig[i] <= DIG_BLANK;
        end else begin
            r_update_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_cap_val       <= data_in;
                        r_cap_mode      <= hex_mode;
                        r_force_pending <= 1'b0;
                    end
                end
                S_LOAD: begin
                    r_bcd  <= 12'd0;
                    r_bin  <= r_cap_val;
                    r_iter <= 3'd0;
                end
                S_CONVERT: begin
                    {r_bcd, r_bin} <= {w_bcd_adj[10:0], r_bin, 1'b0};
                    r_iter         <= r_iter + 3'd1;
                end
                S_COMMIT: begin
                    r_update_done <= 1'b1;
                    if (r_cap_mode) begin
                        r_dig[0] <= {1'b0, r_cap_val[3:0]};
                        r_dig[1] <= {1'b0, r_cap_val[7:4]};
                    end else begin
                        r_dig[0] <= {1'b0, r_bcd[3:0]};
                        r_dig[1] <= {(r_bcd[11:8] == 4'd0) && (r_bcd[7:4] == 4'd0), r_bcd[7:4]};
                    end
                    r_dig[2] <= (r_cap_mode || (r_bcd[11:8] == 4'd0)) ? DIG_BLANK : {1'b0, r_bcd[11:8]};
                    r_dig[3] <= DIG_BLANK;
                end
                default: ;
            endcase
        end
    end

    // Free-running brightness PWM counter and blink half-period timer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pwm_cnt     <= '0;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else begin
            if (r_pwm_cnt == PCW'(PWM_PERIOD - 1)) r_pwm_cnt <= '0;
            else                                   r_pwm_cnt <= r_pwm_cnt + 1'b1;
            if (r_blink_cnt == BCW'(BLINK_HALF - 1)) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    assign w_dark = (r_pwm_cnt >= PCW'(brightness)) || (blink_en && r_blink_phase);

    // Registered segment outputs, forced dark during PWM off time or blink off phase.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) r_hex[i] <= 8'hFF;
        end else begin
            for (int i = 0; i < 4; i++) r_hex[i] <= w_dark ? 8'hFF : seg_enc(r_dig[i]);
        end
    end

    assign hex0        = r_hex[0];
    assign hex1        = r_hex[1];
    assign hex2        = r_hex[2];
    assign hex3        = r_hex[3];
    assign busy        = (r_state != S_IDLE);
    assign update_done = r_update_done;
    assign o_dbg_state = r_state;

endmodule
